// File: rtl/alu_test_sequencer_pkg.sv
// Shared types and helpers for the ALU board-level test sequencer.
// One-hot state encoding, display constants, sizing functions.
package alu_test_sequencer_pkg;

  localparam int S_LOAD  = 0;
  localparam int S_CTRL  = 1;
  localparam int S_START = 2;
  localparam int S_WAIT  = 3;
  localparam int S_SHOW  = 4;
  localparam int S_ERR   = 5;

  typedef enum logic [5:0] {
    ST_LOAD  = 6'b000001,
    ST_CTRL  = 6'b000010,
    ST_START = 6'b000100,
    ST_WAIT  = 6'b001000,
    ST_SHOW  = 6'b010000,
    ST_ERR   = 6'b100000
  } state_t;

  localparam logic [15:0] ERR_DISP = 16'hEEEE;
  localparam int DISP_W  = 16;
  localparam int LED_MAX = 31;

  function automatic int cdiv(input int a, input int b);
    return (a + b - 1) / b;
  endfunction

  function automatic int cbits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/alu_test_sequencer_disp.sv
// Hex display paging and status LED decode for the ALU sequencer.
// Purely combinational from registered sequencer state.
module alu_test_sequencer_disp
  import alu_test_sequencer_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int FLAG_W = 5,
  parameter int PAGES  = 2,
  parameter int PG_W   = 1,
  parameter int IDX_W  = 2
) (
  input  state_t              state,
  input  logic [IDX_W-1:0]    idx,
  input  logic [PG_W-1:0]     page,
  input  logic [DATA_W-1:0]   result_reg,
  input  logic [FLAG_W-1:0]   flags_reg,
  output logic [15:0]         disp_data,
  output logic                disp_en,
  output logic [15:0]         led
);

  logic [PAGES*DISP_W-1:0] res_pad;
  logic [4:0]              idx_led;
  logic [4:0]              pos_led;
  logic [4:0]              flag_led;

  always_comb begin
    res_pad = '0;
    res_pad[DATA_W-1:0] = result_reg;
  end

  // Load index saturates so large operand sets still show a sane value
  always_comb begin
    idx_led = 5'(idx);
    if (int'(idx) > LED_MAX) idx_led = 5'(LED_MAX);
  end

  always_comb begin
    pos_led  = state[S_LOAD] ? idx_led : 5'(page);
    flag_led = state[S_SHOW] ? 5'(flags_reg) : 5'd0;
    led      = {flag_led, pos_led, state};
  end

  always_comb begin
    disp_data = '0;
    disp_en   = 1'b0;
    unique case (1'b1)
      state[S_SHOW]: begin
        disp_en   = 1'b1;
        disp_data = res_pad[page*DISP_W +: DISP_W];
      end
      state[S_ERR]: begin
        disp_en   = 1'b1;
        disp_data = ERR_DISP;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_test_sequencer.sv
// Switch/button driven stimulus and readback sequencer for float_alu.
// Loads operands in chunks, fires one start, waits with timeout, pages result.
module alu_test_sequencer
  import alu_test_sequencer_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int SW_W    = 16,
  parameter int N_OPS   = 2,
  parameter int CTRL_W  = 5,
  parameter int FLAG_W  = 5,
  parameter int TIMEOUT = 1024
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [SW_W-1:0]           sw,
  input  logic                      step,
  input  logic                      abort,
  output logic [N_OPS*DATA_W-1:0]   ops,
  output logic [CTRL_W-1:0]         ctrl,
  output logic                      start,
  input  logic                      valid_in,
  input  logic [DATA_W-1:0]         result,
  input  logic [FLAG_W-1:0]         flags,
  output logic [15:0]               disp_data,
  output logic                      disp_en,
  output logic [15:0]               led
);

  localparam int CHUNKS = cdiv(DATA_W, SW_W);
  localparam int PAGES  = cdiv(DATA_W, DISP_W);
  localparam int NLOAD  = N_OPS * CHUNKS;
  localparam int IDX_W  = cbits(NLOAD);
  localparam int PG_W   = cbits(PAGES);
  localparam int CNT_W  = cbits(TIMEOUT);

  state_t             state, state_next;
  logic [IDX_W-1:0]   idx;
  logic [PG_W-1:0]    page;
  logic [CNT_W-1:0]   cnt;
  logic [DATA_W-1:0]  result_reg;
  logic [FLAG_W-1:0]  flags_reg;

  logic wr_chunk, ctrl_ld, res_ld, page_inc;
  logic last_chunk, timeout_hit, last_page;

  assign last_chunk  = (idx == IDX_W'(NLOAD - 1));
  assign timeout_hit = (cnt == CNT_W'(TIMEOUT - 1));
  assign last_page   = (page == PG_W'(PAGES - 1));

  always_comb begin
    state_next = state;
    wr_chunk   = 1'b0;
    ctrl_ld    = 1'b0;
    res_ld     = 1'b0;
    page_inc   = 1'b0;
    if (abort) begin
      state_next = ST_LOAD;
    end else begin
      unique case (state)
        ST_LOAD: begin
          if (step) begin
            wr_chunk = 1'b1;
            if (last_chunk) state_next = ST_CTRL;
          end
        end
        ST_CTRL: begin
          if (step) begin
            ctrl_ld    = 1'b1;
            state_next = ST_START;
          end
        end
        ST_START: state_next = ST_WAIT;
        ST_WAIT: begin
          if (valid_in) begin
            res_ld     = 1'b1;
            state_next = ST_SHOW;
          end else if (timeout_hit) begin
            state_next = ST_ERR;
          end
        end
        ST_SHOW: page_inc = step;
        ST_ERR: begin
          if (step) state_next = ST_LOAD;
        end
        default: state_next = ST_LOAD;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_LOAD;
      idx        <= '0;
      page       <= '0;
      cnt        <= '0;
      ops        <= '0;
      ctrl       <= '0;
      start      <= 1'b0;
      result_reg <= '0;
      flags_reg  <= '0;
    end else begin
      state <= state_next;
      start <= (state_next == ST_START);

      if (abort) begin
        idx  <= '0;
        page <= '0;
      end else begin
        if (wr_chunk) idx <= last_chunk ? '0 : idx + 1'b1;
        if (res_ld) page <= '0;
        else if (page_inc) page <= last_page ? '0 : page + 1'b1;
      end

      if (ctrl_ld) ctrl <= sw[CTRL_W-1:0];

      if (res_ld) begin
        result_reg <= result;
        flags_reg  <= flags;
      end

      if (state == ST_START) cnt <= '0;
      else if (state == ST_WAIT) cnt <= cnt + 1'b1;

      // Chunk bits beyond DATA_W are dropped on the last chunk of each operand
      if (wr_chunk) begin
        for (int k = 0; k < N_OPS; k++) begin
          for (int c = 0; c < CHUNKS; c++) begin
            if (idx == IDX_W'(k * CHUNKS + c)) begin
              for (int b = 0; b < SW_W; b++) begin
                if (c * SW_W + b < DATA_W)
                  ops[k*DATA_W + c*SW_W + b] <= sw[b];
              end
            end
          end
        end
      end
    end
  end

  alu_test_sequencer_disp #(
    .DATA_W (DATA_W),
    .FLAG_W (FLAG_W),
    .PAGES  (PAGES),
    .PG_W   (PG_W),
    .IDX_W  (IDX_W)
  ) u_disp (
    .state      (state),
    .idx        (idx),
    .page       (page),
    .result_reg (result_reg),
    .flags_reg  (flags_reg),
    .disp_data  (disp_data),
    .disp_en    (disp_en),
    .led        (led)
  );

endmodule

// File: tb/tb_alu_test_sequencer.sv
// Directed bench for alu_test_sequencer: default 32-bit build (short timeout)
// plus a 24-bit / 8-bit switch / 3-operand build.
module tb_alu_test_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;

  logic [15:0] sw;
  logic        step, abort, valid_in;
  logic [31:0] result;
  logic [4:0]  flags;
  logic [63:0] ops;
  logic [4:0]  ctrl;
  logic        start;
  logic [15:0] disp_data;
  logic        disp_en;
  logic [15:0] led;

  logic [7:0]  sw1;
  logic        step1, abort1, valid1;
  logic [23:0] result1;
  logic [4:0]  flags1;
  logic [71:0] ops1;
  logic [4:0]  ctrl1;
  logic        start1;
  logic [15:0] disp1;
  logic        disp_en1;
  logic [15:0] led1;

  int errors = 0;
  int checks = 0;

  alu_test_sequencer #(
    .DATA_W(32), .SW_W(16), .N_OPS(2),
    .CTRL_W(5), .FLAG_W(5), .TIMEOUT(16)
  ) u0 (
    .clk(clk), .rst_n(rst_n), .sw(sw), .step(step), .abort(abort),
    .ops(ops), .ctrl(ctrl), .start(start), .valid_in(valid_in),
    .result(result), .flags(flags), .disp_data(disp_data),
    .disp_en(disp_en), .led(led)
  );

  alu_test_sequencer #(
    .DATA_W(24), .SW_W(8), .N_OPS(3),
    .CTRL_W(5), .FLAG_W(5), .TIMEOUT(1024)
  ) u1 (
    .clk(clk), .rst_n(rst_n), .sw(sw1), .step(step1), .abort(abort1),
    .ops(ops1), .ctrl(ctrl1), .start(start1), .valid_in(valid1),
    .result(result1), .flags(flags1), .disp_data(disp1),
    .disp_en(disp_en1), .led(led1)
  );

  task automatic chk(input string tag, input logic [127:0] obs,
                     input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse(input logic [15:0] v);
    sw = v; step = 1'b1;
    @(negedge clk);
    step = 1'b0;
  endtask

  task automatic pulse1(input logic [7:0] v);
    sw1 = v; step1 = 1'b1;
    @(negedge clk);
    step1 = 1'b0;
  endtask

  task automatic load4(input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] c, input logic [15:0] d);
    pulse(a); pulse(b); pulse(c); pulse(d);
  endtask

  initial begin
    rst_n = 1'b0;
    sw = '0; step = 0; abort = 0; valid_in = 0; result = '0; flags = '0;
    sw1 = '0; step1 = 0; abort1 = 0; valid1 = 0; result1 = '0; flags1 = '0;
    tick(2);
    chk("rst_led", led, 16'h0001);
    chk("rst_ops", ops, 64'h0);
    chk("rst_ctrl", ctrl, 5'h0);
    chk("rst_start", start, 1'b0);
    chk("rst_disp_en", disp_en, 1'b0);
    chk("rst_disp", disp_data, 16'h0);
    chk("rst_led1", led1, 16'h0001);
    chk("rst_ops1", ops1, 72'h0);
    rst_n = 1'b1;
    tick(1);

    pulse(16'h1111); pulse(16'h2222);
    chk("idx2", led[10:0], {5'd2, 6'b000001});
    pulse(16'h3333); pulse(16'h4444);
    chk("ops_load", ops, 64'h4444_3333_2222_1111);
    chk("st_ctrl", led[5:0], 6'b000010);

    pulse(16'h0013);
    chk("ctrl_val", ctrl, 5'h13);
    chk("start_hi", start, 1'b1);
    chk("st_start", led[5:0], 6'b000100);
    tick(1);
    chk("start_lo", start, 1'b0);
    chk("st_wait", led[5:0], 6'b001000);

    tick(5);
    valid_in = 1'b1; result = 32'h3F80_0000; flags = 5'b00001;
    tick(1);
    valid_in = 1'b0;
    chk("st_show", led[5:0], 6'b010000);
    chk("show_en", disp_en, 1'b1);
    chk("page0", disp_data, 16'h0000);
    chk("led_flags", led[15:11], 5'b00001);
    pulse(16'h0);
    chk("page1", disp_data, 16'h3F80);
    chk("led_page1", led[10:6], 5'd1);
    pulse(16'h0);
    chk("page_wrap", disp_data, 16'h0000);

    valid_in = 1'b1; result = 32'hDEAD_BEEF; flags = 5'h1F;
    tick(1);
    valid_in = 1'b0;
    pulse(16'h0);
    chk("valid_ignored", disp_data, 16'h3F80);
    chk("flags_kept", led[15:11], 5'b00001);

    abort = 1'b1; tick(1); abort = 1'b0;
    chk("abort_show", led, 16'h0001);
    chk("ops_kept", ops, 64'h4444_3333_2222_1111);

    load4(16'h5555, 16'h6666, 16'h7777, 16'h8888);
    pulse(16'h0007);
    tick(1);
    chk("to_wait", led[5:0], 6'b001000);
    tick(15);
    chk("to_still_wait", led[5:0], 6'b001000);
    tick(1);
    chk("to_err", led[5:0], 6'b100000);
    chk("err_disp", disp_data, 16'hEEEE);
    chk("err_en", disp_en, 1'b1);
    pulse(16'h0);
    chk("err_to_load", led, 16'h0001);

    pulse(16'hAAAA); pulse(16'hBBBB);
    chk("idx2b", led[10:6], 5'd2);
    sw = 16'hCCCC; step = 1'b1; abort = 1'b1;
    tick(1);
    step = 1'b0; abort = 1'b0;
    chk("abort_step", led, 16'h0001);
    chk("abort_nowr", ops, 64'h8888_7777_BBBB_AAAA);

    load4(16'h0001, 16'h0002, 16'h0003, 16'h0004);
    pulse(16'h0005);
    chk("start2_hi", start, 1'b1);
    abort = 1'b1; tick(1); abort = 1'b0;
    chk("abort_start", start, 1'b0);
    chk("abort_start_st", led, 16'h0001);
    chk("ctrl_kept", ctrl, 5'h05);

    load4(16'h0009, 16'h0008, 16'h0007, 16'h0006);
    pulse(16'h0002);
    tick(4);
    chk("mid_wait", led[5:0], 6'b001000);
    rst_n = 1'b0;
    tick(1);
    chk("rst2_ops", ops, 64'h0);
    chk("rst2_ctrl", ctrl, 5'h0);
    chk("rst2_led", led, 16'h0001);
    chk("rst2_en", disp_en, 1'b0);
    rst_n = 1'b1;
    tick(1);

    for (int i = 1; i <= 8; i++) pulse1(8'(i));
    chk("u1_idx8", led1[10:0], {5'd8, 6'b000001});
    pulse1(8'h09);
    chk("u1_ops", ops1, 72'h09_0807_0605_0403_0201);
    chk("u1_ctrl_st", led1[5:0], 6'b000010);
    pulse1(8'h3F);
    chk("u1_ctrl", ctrl1, 5'h1F);
    chk("u1_start", start1, 1'b1);
    tick(1);
    chk("u1_wait", led1[5:0], 6'b001000);
    valid1 = 1'b1; result1 = 24'hABCDEF; flags1 = 5'b10100;
    tick(1);
    valid1 = 1'b0;
    chk("u1_page0", disp1, 16'hCDEF);
    chk("u1_flags", led1[15:11], 5'b10100);
    pulse1(8'h0);
    chk("u1_page1", disp1, 16'h00AB);
    pulse1(8'h0);
    chk("u1_wrap", disp1, 16'hCDEF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
